instruction_decoder: RTL and testbench

//  Consumer end of the program-sequencer control interface. Registers the program-memory

---
 rtl/instr_pkg.sv | 16 +
 rtl/loop_counter.sv | 37 +++
 rtl/instruction_decoder.sv | 79 +++++++
 tb/tb_instruction_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared opcode encoding and default widths for the instruction decoder slice.
package instr_pkg;

  localparam int unsigned IwDefault = 8;
  localparam int unsigned AwDefault = 4;
  localparam int unsigned CwDefault = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_JMP = 4'h1,
    OP_JNZ = 4'h2,
    OP_LDC = 4'h3,
    OP_DEC = 4'h4
  } opcode_e;

endpackage

// File: rtl/loop_counter.sv
// Loop counter with synchronous load and a decrement that saturates at zero.
module loop_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          sync_reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Reset takes priority over any load/decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/instruction_decoder.sv
// Registers the program-memory word into ir and decodes it into jump requests for the
// program sequencer; owns the loop counter that resolves JNZ.
module instruction_decoder
  import instr_pkg::*;
#(
  parameter int unsigned IW = IwDefault,
  parameter int unsigned AW = AwDefault,
  parameter int unsigned CW = CwDefault
) (
  input  logic          clk,
  input  logic          sync_reset_n,
  input  logic [IW-1:0] pm_data,
  output logic          jmp,
  output logic          jmp_nz,
  output logic [AW-1:0] jmp_addr,
  output logic          dont_jmp,
  output logic [IW-1:0] ir,
  output logic [CW-1:0] loop_cnt,
  output logic [7:0]    from_ID
);

  logic [IW-AW-1:0] op;
  logic [AW-1:0]    operand;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      ir <= '0;
    end else begin
      ir <= pm_data;
    end
  end

  assign op      = ir[IW-1:AW];
  assign operand = ir[AW-1:0];

  // Outputs are gated by reset so a NOP is presented even before the first reset edge.
  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    jmp_addr = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (sync_reset_n) begin
      case (op)
        (IW-AW)'(OP_JMP): begin
          jmp      = 1'b1;
          jmp_addr = operand;
        end
        (IW-AW)'(OP_JNZ): begin
          jmp_nz   = 1'b1;
          jmp_addr = operand;
          cnt_dec  = 1'b1;
        end
        (IW-AW)'(OP_LDC): cnt_load = 1'b1;
        (IW-AW)'(OP_DEC): cnt_dec  = 1'b1;
        default: ;
      endcase
    end
  end

  loop_counter #(
    .CW (CW)
  ) u_loop_counter (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .load         (cnt_load),
    .dec          (cnt_dec),
    .load_val     (CW'(operand)),
    .cnt          (loop_cnt),
    .zero         (cnt_zero)
  );

  assign dont_jmp = !sync_reset_n || cnt_zero;
  assign from_ID  = 8'h00;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench: directed vector table followed by randomized instruction streams.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic [7:0] pm_data;
  logic       jmp, jmp_nz, dont_jmp;
  logic [3:0] jmp_addr;
  logic [7:0] ir;
  logic [3:0] loop_cnt;
  logic [7:0] from_ID;

  int checks = 0;
  int errors = 0;

  // Reference state: what ir and the loop counter should hold.
  logic [7:0] m_ir  = 8'h00;
  int         m_cnt = 0;

  instruction_decoder #(
    .IW (8),
    .AW (4),
    .CW (4)
  ) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .pm_data      (pm_data),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .jmp_addr     (jmp_addr),
    .dont_jmp     (dont_jmp),
    .ir           (ir),
    .loop_cnt     (loop_cnt),
    .from_ID      (from_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pm;
    logic       rn;
    logic [7:0] e_ir;
    logic       e_jmp;
    logic       e_jnz;
    logic [3:0] e_addr;
    logic       e_dont;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level model of one clock edge.
  task automatic model_edge(input logic [7:0] pm, input logic rn);
    int op;
    op = int'(m_ir[7:4]);
    if (!rn) begin
      m_cnt = 0;
      m_ir  = 8'h00;
    end else begin
      if (op == 3) m_cnt = int'(m_ir[3:0]);
      else if ((op == 2 || op == 4) && m_cnt > 0) m_cnt = m_cnt - 1;
      m_ir = pm;
    end
  endtask

  task automatic check_model(input logic rn, input string tag);
    int op;
    bit is_j;
    op   = int'(m_ir[7:4]);
    is_j = rn && (op == 1 || op == 2);
    check({tag, ".ir"},       int'(ir),       int'(m_ir));
    check({tag, ".loop_cnt"}, int'(loop_cnt), m_cnt);
    check({tag, ".jmp"},      int'(jmp),      int'(rn && op == 1));
    check({tag, ".jmp_nz"},   int'(jmp_nz),   int'(rn && op == 2));
    check({tag, ".jmp_addr"}, int'(jmp_addr), is_j ? int'(m_ir[3:0]) : 0);
    check({tag, ".dont_jmp"}, int'(dont_jmp), int'(!rn || m_cnt == 0));
    check({tag, ".from_ID"},  int'(from_ID),  0);
  endtask

  task automatic step(input logic [7:0] pm, input logic rn);
    pm_data      = pm;
    sync_reset_n = rn;
    @(posedge clk);
    model_edge(pm, rn);
    @(negedge clk);
  endtask

  task automatic add(input logic [7:0] pm, input logic rn, input logic [7:0] e_ir,
                     input logic e_jmp, input logic e_jnz, input logic [3:0] e_addr,
                     input logic e_dont, input logic [3:0] e_cnt);
    vec_t v;
    v.pm = pm; v.rn = rn; v.e_ir = e_ir; v.e_jmp = e_jmp; v.e_jnz = e_jnz;
    v.e_addr = e_addr; v.e_dont = e_dont; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] pm;
    logic       rn;
    string      tag;

    pm_data      = 8'h1A;
    sync_reset_n = 1'b0;

    //  pm     rn    ir     jmp   jnz   addr  dont  cnt
    add(8'h1A, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // reset held
    add(8'h1A, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);
    add(8'h15, 1'b1, 8'h15, 1'b1, 1'b0, 4'h5, 1'b1, 4'd0);  // JMP 5
    add(8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // LDC 3
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd3);  // JNZ taken
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd2);
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd1);
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b1, 4'd0);  // 4th JNZ not taken
    add(8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // JNZ at 0: no wrap
    add(8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // DEC at 0 saturates
    add(8'hF7, 1'b1, 8'hF7, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // reserved
    add(8'h35, 1'b1, 8'h35, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // LDC 5
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd5);
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd4);
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd3);
    add(8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 4'h2, 1'b0, 4'd2);  // cnt=2, JNZ in ir
    add(8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // reset mid-loop
    add(8'h37, 1'b1, 8'h37, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // LDC 7
    add(8'hF7, 1'b1, 8'hF7, 1'b0, 1'b0, 4'h0, 1'b0, 4'd7);  // reserved keeps cnt
    add(8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 4'h0, 1'b0, 4'd7);
    add(8'h4F, 1'b1, 8'h4F, 1'b0, 1'b0, 4'h0, 1'b0, 4'd7);  // DEC
    add(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'd6);
    add(8'h1F, 1'b1, 8'h1F, 1'b1, 1'b0, 4'hF, 1'b0, 4'd6);  // JMP F
    add(8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 4'h0, 1'b0, 4'd6);  // LDC 12 in ir
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);  // reset beats LDC

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].pm, vecs[i].rn);
      tag = $sformatf("vec%0d", i);
      check({tag, ".ir"},       int'(ir),       int'(vecs[i].e_ir));
      check({tag, ".jmp"},      int'(jmp),      int'(vecs[i].e_jmp));
      check({tag, ".jmp_nz"},   int'(jmp_nz),   int'(vecs[i].e_jnz));
      check({tag, ".jmp_addr"}, int'(jmp_addr), int'(vecs[i].e_addr));
      check({tag, ".dont_jmp"}, int'(dont_jmp), int'(vecs[i].e_dont));
      check({tag, ".loop_cnt"}, int'(loop_cnt), int'(vecs[i].e_cnt));
      check({tag, ".from_ID"},  int'(from_ID),  0);
    end

    // Random streams, opcodes biased toward the defined ones.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) pm = {4'($urandom_range(0, 4)), 4'($urandom)};
      else pm = 8'($urandom);
      rn = ($urandom_range(0, 24) != 0);
      step(pm, rn);
      check_model(rn, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
